// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - Header offsets, protocol constants and FSM state type for the UDP receive dispatcher.
package udp_rx_pkg;

  localparam logic [5:0] OFF_ETYPE       = 6'd12;
  localparam logic [5:0] OFF_IPHDR_FIRST = 6'd14;
  localparam logic [5:0] OFF_PROTO       = 6'd23;
  localparam logic [5:0] OFF_SRCIP_LO    = 6'd29;
  localparam logic [5:0] OFF_IPHDR_LAST  = 6'd33;
  localparam logic [5:0] OFF_DPORT       = 6'd36;
  localparam logic [5:0] OFF_ULEN        = 6'd38;
  localparam logic [5:0] HDR_LEN         = 6'd42;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} udp_rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// rtl/ipv4_csum_acc.sv - Byte-serial IPv4 header one's-complement accumulator.
// Only instantiated when UDP_RX_IPCSUM_EN is defined.
module ipv4_csum_acc (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       sum_ok_o
);

  logic [15:0] sum_q, sum_d;
  logic [7:0]  hi_q, hi_d;
  logic        odd_q, odd_d;
  logic [16:0] add;

  // Bytes pair up big-endian; the carry out of each word add wraps back into bit 0.
  always_comb begin
    sum_d = sum_q;
    hi_d  = hi_q;
    odd_d = odd_q;
    add   = {1'b0, sum_q} + {1'b0, hi_q, byte_i};
    if (start_i) begin
      sum_d = '0;
      hi_d  = '0;
      odd_d = 1'b0;
    end else if (byte_valid_i) begin
      if (!odd_q) begin
        hi_d = byte_i;
      end else begin
        sum_d = add[15:0] + {15'd0, add[16]};
      end
      odd_d = !odd_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      hi_q  <= hi_d;
      odd_q <= odd_d;
    end
  end

  assign sum_ok_o = (sum_q == 16'hFFFF);

endmodule

// File: rtl/udp_rx_port_dispatch.sv
// rtl/udp_rx_port_dispatch.sv - Strips Ethernet/IPv4/UDP headers and steers payloads to per-board data/direct streams.
// Define UDP_RX_IPCSUM_EN to also drop frames whose IPv4 header checksum is wrong.
module udp_rx_port_dispatch
  import udp_rx_pkg::*;
#(
  parameter int         BOARD_TOTAL   = 4,
  parameter logic [7:0] BOARD_IP_BASE = 8'd16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [15:0]                   fpga_udp_data_port,
  input  logic [15:0]                   fpga_udp_dire_port,
  input  logic [7:0]                    rx_frame_8bit_tdata,
  input  logic                          rx_frame_8bit_tvalid,
  output logic                          rx_frame_8bit_tready,
  input  logic                          rx_frame_8bit_tlast,
  output logic [BOARD_TOTAL-1:0][7:0]   rx_udp_data_8bit_tdata,
  output logic [BOARD_TOTAL-1:0]        rx_udp_data_8bit_tvalid,
  input  logic [BOARD_TOTAL-1:0]        rx_udp_data_8bit_tready,
  output logic [BOARD_TOTAL-1:0]        rx_udp_data_8bit_tlast,
  output logic [BOARD_TOTAL-1:0][7:0]   rx_udp_dire_8bit_tdata,
  output logic [BOARD_TOTAL-1:0]        rx_udp_dire_8bit_tvalid,
  input  logic [BOARD_TOTAL-1:0]        rx_udp_dire_8bit_tready,
  output logic [BOARD_TOTAL-1:0]        rx_udp_dire_8bit_tlast,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   short_cnt
);

  localparam int         BW            = (BOARD_TOTAL > 1) ? $clog2(BOARD_TOTAL) : 1;
  localparam logic [8:0] BOARD_TOTAL_L = 9'(BOARD_TOTAL);

  udp_rx_state_e   state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [15:0]     etype_q, etype_d;
  logic [7:0]      proto_q, proto_d;
  logic [7:0]      srcip_q, srcip_d;
  logic [15:0]     dport_q, dport_d;
  logic [15:0]     ulen_q, ulen_d;
  logic [15:0]     rem_q, rem_d;
  logic [BW-1:0]   board_q, board_d;
  logic            dire_q, dire_d;
  logic [15:0]     drop_q, drop_d;
  logic [15:0]     short_q, short_d;

  logic            rx_beat;
  logic            hdr_beat;
  logic            last_beat;
  logic [7:0]      board_diff;
  logic            board_ok;
  logic            is_data;
  logic            is_dire;
  logic            csum_ok;
  logic            checks_ok;
  logic            has_payload;

  assign rx_beat   = rx_frame_8bit_tvalid & rx_frame_8bit_tready;
  assign hdr_beat  = (state_q == HDR) & rx_beat;
  assign last_beat = (rem_q == 16'd1);

`ifdef UDP_RX_IPCSUM_EN
  ipv4_csum_acc u_csum (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .start_i      (hdr_beat && (cnt_q == 6'd0)),
    .byte_valid_i (hdr_beat && (cnt_q >= OFF_IPHDR_FIRST) && (cnt_q <= OFF_IPHDR_LAST)),
    .byte_i       (rx_frame_8bit_tdata),
    .sum_ok_o     (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // Board index wraps in 8 bits so addresses below the base land far out of range.
  assign board_diff  = srcip_q - BOARD_IP_BASE;
  assign board_ok    = {1'b0, board_diff} < BOARD_TOTAL_L;
  assign is_data     = (dport_q == fpga_udp_data_port);
  assign is_dire     = !is_data && (dport_q == fpga_udp_dire_port);
  assign has_payload = (ulen_q > UDP_HDR_LEN);
  assign checks_ok   = (etype_q == ETYPE_IPV4) && (proto_q == PROTO_UDP) && board_ok
                       && (is_data || is_dire) && csum_ok;

  // Payload is a zero-latency pass-through to exactly one selected master.
  always_comb begin
    rx_frame_8bit_tready    = 1'b1;
    rx_udp_data_8bit_tdata  = '0;
    rx_udp_data_8bit_tvalid = '0;
    rx_udp_data_8bit_tlast  = '0;
    rx_udp_dire_8bit_tdata  = '0;
    rx_udp_dire_8bit_tvalid = '0;
    rx_udp_dire_8bit_tlast  = '0;
    if (state_q == PAYLOAD) begin
      if (dire_q) begin
        rx_frame_8bit_tready            = rx_udp_dire_8bit_tready[board_q];
        rx_udp_dire_8bit_tdata[board_q]  = rx_frame_8bit_tdata;
        rx_udp_dire_8bit_tvalid[board_q] = rx_frame_8bit_tvalid;
        rx_udp_dire_8bit_tlast[board_q]  = rx_frame_8bit_tlast | last_beat;
      end else begin
        rx_frame_8bit_tready            = rx_udp_data_8bit_tready[board_q];
        rx_udp_data_8bit_tdata[board_q]  = rx_frame_8bit_tdata;
        rx_udp_data_8bit_tvalid[board_q] = rx_frame_8bit_tvalid;
        rx_udp_data_8bit_tlast[board_q]  = rx_frame_8bit_tlast | last_beat;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    etype_d = etype_q;
    proto_d = proto_q;
    srcip_d = srcip_q;
    dport_d = dport_q;
    ulen_d  = ulen_q;
    rem_d   = rem_q;
    board_d = board_q;
    dire_d  = dire_q;
    drop_d  = drop_q;
    short_d = short_q;
    case (state_q)
      HDR: begin
        if (rx_beat) begin
          cnt_d = cnt_q + 6'd1;
          case (cnt_q)
            OFF_ETYPE:          etype_d[15:8] = rx_frame_8bit_tdata;
            OFF_ETYPE + 6'd1:   etype_d[7:0]  = rx_frame_8bit_tdata;
            OFF_PROTO:          proto_d       = rx_frame_8bit_tdata;
            OFF_SRCIP_LO:       srcip_d       = rx_frame_8bit_tdata;
            OFF_DPORT:          dport_d[15:8] = rx_frame_8bit_tdata;
            OFF_DPORT + 6'd1:   dport_d[7:0]  = rx_frame_8bit_tdata;
            OFF_ULEN:           ulen_d[15:8]  = rx_frame_8bit_tdata;
            OFF_ULEN + 6'd1:    ulen_d[7:0]   = rx_frame_8bit_tdata;
            default: ;
          endcase
          if (cnt_q == HDR_LEN - 6'd1) begin
            cnt_d = '0;
            if (!checks_ok) begin
              drop_d  = sat_inc16(drop_q);
              state_d = rx_frame_8bit_tlast ? HDR : DROP;
            end else if (rx_frame_8bit_tlast) begin
              state_d = HDR;
            end else if (!has_payload) begin
              state_d = DROP;
            end else begin
              state_d = PAYLOAD;
              rem_d   = ulen_q - UDP_HDR_LEN;
              board_d = board_diff[BW-1:0];
              dire_d  = !is_data;
            end
          end else if (rx_frame_8bit_tlast) begin
            cnt_d  = '0;
            drop_d = sat_inc16(drop_q);
          end
        end
      end
      PAYLOAD: begin
        if (rx_beat) begin
          rem_d = rem_q - 16'd1;
          if (last_beat) begin
            state_d = rx_frame_8bit_tlast ? HDR : DROP;
          end else if (rx_frame_8bit_tlast) begin
            short_d = sat_inc16(short_q);
            state_d = HDR;
          end
        end
      end
      DROP: begin
        if (rx_beat && rx_frame_8bit_tlast) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HDR;
      cnt_q   <= '0;
      etype_q <= '0;
      proto_q <= '0;
      srcip_q <= '0;
      dport_q <= '0;
      ulen_q  <= '0;
      rem_q   <= '0;
      board_q <= '0;
      dire_q  <= 1'b0;
      drop_q  <= '0;
      short_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      etype_q <= etype_d;
      proto_q <= proto_d;
      srcip_q <= srcip_d;
      dport_q <= dport_d;
      ulen_q  <= ulen_d;
      rem_q   <= rem_d;
      board_q <= board_d;
      dire_q  <= dire_d;
      drop_q  <= drop_d;
      short_q <= short_d;
    end
  end

  assign drop_cnt  = drop_q;
  assign short_cnt = short_q;

endmodule
